// File: rtl/vga_frame_scanner.sv
// VGA frame scanner: walks the sync/porch/active raster, fetches RGB565 pixels from frame memory
// and drives RGB888 plus syncs. Define VGA_TEST_PATTERN_EN to add the i_pattern colour-bar source.

module vga_frame_scanner #(
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int ADDR_W    = 20,
  parameter int BASE_ADDR = 0
) (
  input  logic              i_clk_25M,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_scale2x,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              i_pattern,
`endif
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [15:0]       i_rd_data,
  output logic [7:0]        o_VGA_R,
  output logic [7:0]        o_VGA_G,
  output logic [7:0]        o_VGA_B,
  output logic              o_VGA_HS,
  output logic              o_VGA_VS,
  output logic              o_VGA_BLANK_N,
  output logic              o_VGA_SYNC_N,
  output logic              o_VGA_CLK,
  output logic              o_busy,
  output logic              o_frame_done
);

  localparam int H_TOTAL     = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL     = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int H_ACT_START = H_SYNC + H_BACK;
  localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
  localparam int V_ACT_START = V_SYNC + V_BACK;
  localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;
  localparam int H_CW        = $clog2(H_TOTAL);
  localparam int V_CW        = $clog2(V_TOTAL);
  localparam logic V_START_ODD = 1'(V_ACT_START % 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic              drain_cnt;
  logic [H_CW-1:0]   h_cnt;
  logic [V_CW-1:0]   v_cnt;
  logic              h_last, v_last, frame_last, run;
  logic              scale_q;
  logic [ADDR_W-1:0] line_base;

  logic              h_in_act, v_in_act, active;
  logic [H_CW-1:0]   h_act;
  logic              v_act_odd;
  logic              load, rd_req_c;
  logic [ADDR_W-1:0] col_off;

  logic              hs_d1, vs_d1, blank_d1, load_d1, done_d1;
  logic [23:0]       rgb_q;
  logic              pat_sel_d1;
  logic [23:0]       pat_rgb_d1;

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  assign run        = (state == RUN);
  assign h_last     = (h_cnt == H_CW'(H_TOTAL - 1));
  assign v_last     = (v_cnt == V_CW'(V_TOTAL - 1));
  assign frame_last = h_last && v_last;

  always_ff @(posedge i_clk_25M) begin
    if (i_rst) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) && !drain_cnt;
    end
  end

  // Leaving RUN is only allowed at the final count so a frame is never cut short.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_en) state_nxt = RUN;
      RUN:     if (frame_last && !i_en) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_25M) begin
    if (i_rst || !run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + V_CW'(1);
    end else begin
      h_cnt <= h_cnt + H_CW'(1);
    end
  end

  always_ff @(posedge i_clk_25M) begin
    if (i_rst)
      scale_q <= 1'b0;
    else if ((state == IDLE && i_en) || (run && frame_last))
      scale_q <= i_scale2x;
  end

  assign h_in_act  = (h_cnt >= H_CW'(H_ACT_START)) && (h_cnt < H_CW'(H_ACT_END));
  assign v_in_act  = (v_cnt >= V_CW'(V_ACT_START)) && (v_cnt < V_CW'(V_ACT_END));
  assign active    = run && h_in_act && v_in_act;
  assign h_act     = h_cnt - H_CW'(H_ACT_START);
  assign v_act_odd = v_cnt[0] ^ V_START_ODD;

  // In 2x mode only even columns capture new data; odd lines reuse the row via the address bus.
  assign load     = active && (!scale_q || !h_act[0]);
  assign rd_req_c = active && (!scale_q || (!h_act[0] && !v_act_odd));

  always_comb begin
    col_off = '0;
    if (active)
      col_off = scale_q ? ADDR_W'(h_act >> 1) : ADDR_W'(h_act);
  end

  assign o_rd_addr = ADDR_W'(BASE_ADDR) + line_base + col_off;

  // Line base advances per displayed line (native) or per line pair (2x); no multiplier needed.
  always_ff @(posedge i_clk_25M) begin
    if (i_rst || !run) begin
      line_base <= '0;
    end else if (h_last) begin
      if (v_last)
        line_base <= '0;
      else if (v_in_act && (!scale_q || v_act_odd))
        line_base <= line_base + (scale_q ? ADDR_W'(H_ACTIVE / 2) : ADDR_W'(H_ACTIVE));
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W  = H_ACTIVE / 8;
  localparam int BAR_CW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [BAR_CW-1:0] bar_px;
  logic [2:0]        bar_idx;
  logic [23:0]       bar_rgb;

  always_ff @(posedge i_clk_25M) begin
    if (i_rst || !h_in_act) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (bar_px == BAR_CW'(BAR_W - 1)) begin
      bar_px  <= '0;
      bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_px  <= bar_px + BAR_CW'(1);
    end
  end

  always_comb begin
    bar_rgb = 24'h000000;
    case (bar_idx)
      3'd0: bar_rgb = 24'hFFFFFF;
      3'd1: bar_rgb = 24'hFFFF00;
      3'd2: bar_rgb = 24'h00FFFF;
      3'd3: bar_rgb = 24'h00FF00;
      3'd4: bar_rgb = 24'hFF00FF;
      3'd5: bar_rgb = 24'hFF0000;
      3'd6: bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  always_ff @(posedge i_clk_25M) begin
    if (i_rst) begin
      pat_sel_d1 <= 1'b0;
      pat_rgb_d1 <= '0;
    end else begin
      pat_sel_d1 <= i_pattern;
      pat_rgb_d1 <= bar_rgb;
    end
  end

  assign o_rd_req = rd_req_c && !i_pattern;
`else
  assign pat_sel_d1 = 1'b0;
  assign pat_rgb_d1 = '0;
  assign o_rd_req   = rd_req_c;
`endif

  // Stage 1 lines up the timing strobes with the cycle in which memory data returns.
  always_ff @(posedge i_clk_25M) begin
    if (i_rst) begin
      hs_d1    <= 1'b1;
      vs_d1    <= 1'b1;
      blank_d1 <= 1'b0;
      load_d1  <= 1'b0;
      done_d1  <= 1'b0;
    end else begin
      hs_d1    <= !(run && (h_cnt < H_CW'(H_SYNC)));
      vs_d1    <= !(run && (v_cnt < V_CW'(V_SYNC)));
      blank_d1 <= active;
      load_d1  <= load;
      done_d1  <= run && frame_last;
    end
  end

  always_ff @(posedge i_clk_25M) begin
    if (i_rst) begin
      o_VGA_HS      <= 1'b1;
      o_VGA_VS      <= 1'b1;
      o_VGA_BLANK_N <= 1'b0;
      o_frame_done  <= 1'b0;
      rgb_q         <= '0;
    end else begin
      o_VGA_HS      <= hs_d1;
      o_VGA_VS      <= vs_d1;
      o_VGA_BLANK_N <= blank_d1;
      o_frame_done  <= done_d1;
      if (!blank_d1)
        rgb_q <= '0;
      else if (pat_sel_d1)
        rgb_q <= pat_rgb_d1;
      else if (load_d1)
        rgb_q <= rgb565_to_888(i_rd_data);
    end
  end

  assign o_VGA_R      = o_VGA_BLANK_N ? rgb_q[23:16] : 8'h00;
  assign o_VGA_G      = o_VGA_BLANK_N ? rgb_q[15:8]  : 8'h00;
  assign o_VGA_B      = o_VGA_BLANK_N ? rgb_q[7:0]   : 8'h00;
  assign o_VGA_SYNC_N = 1'b0;
  assign o_VGA_CLK    = i_clk_25M;
  assign o_busy       = (state != IDLE);

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Bench for vga_frame_scanner using a shrunken raster so whole frames fit in a short run.
// Covers colour-bar mode too when built with VGA_TEST_PATTERN_EN.

module tb_vga_frame_scanner;

  localparam int HS = 4, HB = 4, HA = 16, HF = 4;
  localparam int VS = 2, VB = 3, VA = 8,  VF = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FRAME = HT * VT;
  localparam int FIRST_REQ = (VS + VB) * HT + HS + HB;
  localparam int AW = 20;
  localparam int BASE = 256;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1, i_en = 1'b0, i_scale2x = 1'b0;
  logic [15:0]   i_rd_data = '0;
  logic          o_rd_req;
  logic [AW-1:0] o_rd_addr;
  logic [7:0]    o_VGA_R, o_VGA_G, o_VGA_B;
  logic          o_VGA_HS, o_VGA_VS, o_VGA_BLANK_N, o_VGA_SYNC_N, o_VGA_CLK, o_busy, o_frame_done;
`ifdef VGA_TEST_PATTERN_EN
  logic          i_pattern = 1'b0;
`endif

  int n_compared = 0, n_mismatched = 0;

  vga_frame_scanner #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .ADDR_W(AW), .BASE_ADDR(BASE)
  ) dut (
    .i_clk_25M(clk), .i_rst(i_rst), .i_en(i_en), .i_scale2x(i_scale2x),
`ifdef VGA_TEST_PATTERN_EN
    .i_pattern(i_pattern),
`endif
    .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_VGA_R(o_VGA_R), .o_VGA_G(o_VGA_G), .o_VGA_B(o_VGA_B),
    .o_VGA_HS(o_VGA_HS), .o_VGA_VS(o_VGA_VS), .o_VGA_BLANK_N(o_VGA_BLANK_N),
    .o_VGA_SYNC_N(o_VGA_SYNC_N), .o_VGA_CLK(o_VGA_CLK),
    .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  always #20 clk = ~clk;

  // Synchronous frame memory: returns addr[15:0] (or a fixed word) one cycle after the address.
  bit          const_mode = 1'b0;
  logic [15:0] const_val  = '0;
  always @(posedge clk) i_rd_data <= const_mode ? const_val : o_rd_addr[15:0];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] expand565(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

  // Raster monitor: run_cyc counts from the first RUN cycle (h=0, v=0).
  bit          mon_on = 1'b0, mon_started = 1'b0, busy_prev = 1'b0;
  bit          mon_scale[4];
  int          run_cyc, frm, reads[4], first_req, first_blank, disp_idx;
  int          hs_len, vs_len, done_cnt, done_cyc, busy_fall;
  int          m_row, m_col, m_addr;
  logic [15:0] m_d;

  always @(negedge clk) begin
    if (mon_on) begin
      if (!mon_started) begin
        if (o_busy) begin
          mon_started = 1'b1;
          run_cyc     = 0;
          busy_prev   = 1'b1;
        end
      end else begin
        run_cyc++;
        if (busy_prev && !o_busy && busy_fall < 0) busy_fall = run_cyc;
        busy_prev = o_busy;
      end
      if (mon_started) begin
        frm = run_cyc / FRAME;
        if (frm > 3) frm = 3;
        if (run_cyc % FRAME == 0) disp_idx = 0;
        if (o_rd_req) begin
          if (first_req < 0) first_req = run_cyc;
          check_output("rd_addr", o_rd_addr, BASE + reads[frm]);
          reads[frm]++;
        end
        if (o_VGA_BLANK_N) begin
          if (first_blank < 0) first_blank = run_cyc;
          m_row = disp_idx / HA;
          m_col = disp_idx % HA;
          m_addr = mon_scale[frm] ? BASE + (m_row / 2) * (HA / 2) + m_col / 2
                                  : BASE + m_row * HA + m_col;
          m_d = m_addr[15:0];
          check_output("pixel", {o_VGA_R, o_VGA_G, o_VGA_B}, expand565(m_d));
          disp_idx++;
        end else begin
          check_output("rgb_blanked", {o_VGA_R, o_VGA_G, o_VGA_B}, 0);
        end
        if (!o_VGA_HS) hs_len++;
        else if (hs_len > 0) begin
          check_output("hs_width", hs_len, HS);
          hs_len = 0;
        end
        if (!o_VGA_VS) vs_len++;
        else if (vs_len > 0) begin
          check_output("vs_width", vs_len, VS * HT);
          vs_len = 0;
        end
        if (o_frame_done) begin
          done_cnt++;
          done_cyc = run_cyc;
        end
      end
    end
  end

  task automatic mon_begin(input bit s0, input bit s1);
    mon_scale[0] = s0;
    mon_scale[1] = s1;
    mon_scale[2] = s1;
    mon_scale[3] = s1;
    for (int i = 0; i < 4; i++) reads[i] = 0;
    first_req = -1; first_blank = -1; disp_idx = 0;
    hs_len = 0; vs_len = 0; done_cnt = 0; done_cyc = -1; busy_fall = -1;
    mon_started = 1'b0;
    mon_on = 1'b1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_en  = 1'b0;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_busy(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = o_busy;
    end
    check_output(name, seen, 1);
  endtask

  task automatic wait_idle(input string name, input int limit);
    bit idle = 1'b0;
    for (int i = 0; i < limit && !idle; i++) begin
      @(negedge clk);
      idle = !o_busy;
    end
    check_output(name, idle, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_rd_req"},  o_rd_req, 0);
    check_output({tag, "_rd_addr"}, o_rd_addr, BASE);
    check_output({tag, "_rgb"},     {o_VGA_R, o_VGA_G, o_VGA_B}, 0);
    check_output({tag, "_hs"},      o_VGA_HS, 1);
    check_output({tag, "_vs"},      o_VGA_VS, 1);
    check_output({tag, "_blank_n"}, o_VGA_BLANK_N, 0);
    check_output({tag, "_busy"},    o_busy, 0);
    check_output({tag, "_done"},    o_frame_done, 0);
  endtask

  // Runs one monitored frame in the given mode, dropping i_en early so exactly one frame is shown.
  task automatic apply_stimulus(input bit scale, input string tag);
    do_reset();
    i_scale2x = scale;
    mon_begin(scale, scale);
    i_en = 1'b1;
    wait_busy({tag, "_start"});
    repeat (100) @(negedge clk);
    i_en = 1'b0;
    wait_idle({tag, "_drain"}, 2 * FRAME);
    repeat (3) @(negedge clk);
    mon_on = 1'b0;
    check_output({tag, "_reads"}, reads[0], scale ? (HA / 2) * (VA / 2) : HA * VA);
    check_output({tag, "_reads_f1"}, reads[1], 0);
    check_output({tag, "_first_req"}, first_req, FIRST_REQ);
    check_output({tag, "_first_pix"}, first_blank, FIRST_REQ + 2);
    check_output({tag, "_done_cnt"}, done_cnt, 1);
    check_output({tag, "_done_cyc"}, done_cyc, FRAME + 1);
    check_output({tag, "_busy_fall"}, busy_fall, FRAME + 2);
  endtask

  typedef struct {
    logic [15:0] data;
    logic [7:0]  r, g, b;
  } color_vec_t;

  color_vec_t cvec[6];
  int         done_before, n_done, n_busy, n_req;
  bit         found;

  initial begin
    cvec[0] = '{16'hF800, 8'hFF, 8'h00, 8'h00};
    cvec[1] = '{16'h07E0, 8'h00, 8'hFF, 8'h00};
    cvec[2] = '{16'h0010, 8'h00, 8'h00, 8'h84};
    cvec[3] = '{16'hFFFF, 8'hFF, 8'hFF, 8'hFF};
    cvec[4] = '{16'h8410, 8'h84, 8'h82, 8'h84};
    cvec[5] = '{16'h0821, 8'h08, 8'h04, 8'h08};

    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    check_output("sync_n", o_VGA_SYNC_N, 0);
    check_output("vga_clk", o_VGA_CLK, clk);
    i_rst = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs("idle");

    apply_stimulus(1'b0, "native");
    apply_stimulus(1'b1, "scale2x");

    // Mid-frame scale toggles only land at the next frame wrap.
    do_reset();
    i_scale2x = 1'b0;
    mon_begin(1'b0, 1'b1);
    i_en = 1'b1;
    wait_busy("toggle_start");
    repeat (200) @(negedge clk);
    i_scale2x = 1'b1;
    repeat (FRAME) @(negedge clk);
    i_scale2x = 1'b0;
    repeat (80) @(negedge clk);
    i_en = 1'b0;
    done_before = done_cnt;
    wait_idle("toggle_drain", 2 * FRAME);
    repeat (3) @(negedge clk);
    mon_on = 1'b0;
    check_output("toggle_reads_f0", reads[0], HA * VA);
    check_output("toggle_reads_f1", reads[1], (HA / 2) * (VA / 2));
    check_output("toggle_done_after_drop", done_cnt - done_before, 1);
    check_output("toggle_done_cyc", done_cyc, 2 * FRAME + 1);
    check_output("toggle_busy_fall", busy_fall, 2 * FRAME + 2);

    // Reset mid-RUN at h=20, v=10 (inside the active area).
    do_reset();
    i_scale2x = 1'b0;
    i_en = 1'b1;
    wait_busy("midreset_start");
    repeat (10 * HT + 20) @(negedge clk);
    check_output("midreset_pre_req", o_rd_req, 1);
    i_rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    i_rst = 1'b0;
    i_en  = 1'b0;
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_done += o_frame_done;
      n_busy += o_busy;
    end
    check_output("midreset_no_done", n_done, 0);
    check_output("midreset_stay_idle", n_busy, 0);

    // Colour expansion vectors with a constant memory word.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      const_mode = 1'b1;
      const_val  = cvec[v].data;
      i_en = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 2 * FRAME && !found; i++) begin
        @(negedge clk);
        found = o_VGA_BLANK_N;
      end
      check_output("color_active_seen", found, 1);
      check_output("color_r", o_VGA_R, cvec[v].r);
      check_output("color_g", o_VGA_G, cvec[v].g);
      check_output("color_b", o_VGA_B, cvec[v].b);
      found = 1'b0;
      for (int i = 0; i < HT && !found; i++) begin
        @(negedge clk);
        found = !o_VGA_BLANK_N;
      end
      check_output("color_blank_seen", found, 1);
      check_output("color_blank_rgb", {o_VGA_R, o_VGA_G, o_VGA_B}, 0);
      i_en = 1'b0;
    end
    const_mode = 1'b0;

`ifdef VGA_TEST_PATTERN_EN
    begin
      logic [23:0] bars[8];
      int pcol;
      bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
      bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
      do_reset();
      i_pattern = 1'b1;
      i_en = 1'b1;
      @(negedge clk);
      i_en = 1'b0;
      n_req = 0;
      pcol = 0;
      for (int i = 0; i < FRAME + 10; i++) begin
        @(negedge clk);
        n_req += o_rd_req;
        if (o_VGA_BLANK_N && pcol < HA) begin
          check_output("pattern_bar", {o_VGA_R, o_VGA_G, o_VGA_B}, bars[pcol / (HA / 8)]);
          pcol++;
        end
      end
      check_output("pattern_no_reads", n_req, 0);
      check_output("pattern_cols_seen", pcol, HA);
      i_pattern = 1'b0;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #(40 * 40000);
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/vga_frame_scanner.md
VGA_FRAME_SCANNER -- requirements
Module: vga_frame_scanner

Interface
REQ-001 SHALL have parameters: H_SYNC 96, H_BACK 48, H_ACTIVE 640, H_FRONT 16 (horizontal timing, pixel clocks).
REQ-002 SHALL have parameters: V_SYNC 2, V_BACK 33, V_ACTIVE 480, V_FRONT 10 (vertical timing, lines).
REQ-003 SHALL have parameters: ADDR_W 20 (frame-memory address width) and BASE_ADDR 0 (first pixel address of the frame).
REQ-004 Ports (one clock; reset synchronous, active-high):
  i_clk_25M  in  1  pixel clock, all logic on its rising edge.
  i_rst  in  1  synchronous active-high reset.
  i_en  in  1  scan enable.
  i_scale2x  in  1  0 = native resolution, 1 = 2x pixel/line doubling; sampled only at frame start.
  o_rd_req  out  1  frame-memory read strobe.
  o_rd_addr  out  ADDR_W  frame-memory read address.
  i_rd_data  in  16  RGB565 pixel, valid exactly 1 cycle after o_rd_req.
  o_VGA_R / o_VGA_G / o_VGA_B  out  8 each  pixel colour.
  o_VGA_HS / o_VGA_VS  out  1 each  syncs, active-low.
  o_VGA_BLANK_N  out  1  high during the active area.
  o_VGA_SYNC_N  out  1  tied 0.
  o_VGA_CLK  out  1  equals i_clk_25M.
  o_busy  out  1  high while not IDLE.
  o_frame_done  out  1  one-cycle pulse after the last pixel of a frame leaves the pipeline.

Function
REQ-005 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN when i_en=1; RUN->DRAIN when i_en=0 at the last count of a frame (h=H_TOTAL-1, v=V_TOTAL-1); DRAIN->IDLE after 2 cycles; RUN continues into the next frame while i_en=1.
REQ-006 SHALL, with H_TOTAL = sum of the H parameters, run h_cnt 0..H_TOTAL-1 and wrap to 0; v_cnt SHALL increment only on h_cnt wrap and wrap to 0 after V_TOTAL-1.
REQ-007 SHALL order each line and frame as sync, back porch, active, front porch, starting from count 0.
REQ-008 SHALL assert o_rd_req for exactly one cycle per active pixel in native mode, and only on even h and even v counts in 2x mode.
REQ-009 SHALL generate o_rd_addr = BASE_ADDR + row*W + col, where native: row = v_act, col = h_act, W = H_ACTIVE; 2x: row = v_act>>1, col = h_act>>1, W = H_ACTIVE/2.
REQ-010 SHALL compute o_rd_addr with an incrementing line-base register, not a multiplier, and SHALL wrap modulo 2^ADDR_W.
REQ-011 SHALL, in 2x mode, hold the last fetched pixel for the following odd column, and SHALL re-read the same row (same line base) on the odd line.
REQ-012 SHALL delay syncs and BLANK_N by 2 cycles so they align with pixel data (counters -> read -> register); total pixel latency SHALL be 2 cycles from count to pins.
REQ-013 SHALL expand RGB565 to RGB888 by MSB replication: R = {r5, r5[4:2]}, G = {g6, g6[5:4]}, B = {b5, b5[4:2]}.
REQ-014 SHALL drive R, G and B to 0 whenever the delayed BLANK_N is 0.
REQ-015 SHALL latch i_scale2x only on the IDLE->RUN transition and at each frame wrap; mid-frame changes SHALL be ignored.
REQ-016 SHALL, in IDLE, hold o_VGA_HS = 1, o_VGA_VS = 1, o_VGA_BLANK_N = 0, o_rd_req = 0, and keep the counters at 0.

Reset
REQ-017 SHALL, on i_rst=1 at a clock edge, regardless of state: enter IDLE; clear counters, line base and pipeline; drive o_rd_req = 0, o_rd_addr = BASE_ADDR, RGB = 0, HS = VS = 1, BLANK_N = 0, o_busy = 0, o_frame_done = 0.
REQ-018 SHALL give reset priority over i_en; a reset mid-frame SHALL NOT produce o_frame_done.

Configuration
REQ-019 SHALL, with VGA_TEST_PATTERN_EN defined, add input i_pattern (1 bit): when 1, the block SHALL show 8 vertical colour bars (H_ACTIVE/8 wide; white, yellow, cyan, green, magenta, red, blue, black) with o_rd_req held 0 and timing unchanged.
REQ-020 SHALL, with VGA_TEST_PATTERN_EN undefined, have no i_pattern port and no pattern logic.

Verification
REQ-021 Reset mid-RUN (h=300, v=100) -> the next cycle is IDLE, all outputs at reset values, and no o_frame_done pulse.
REQ-022 i_en=1 for one frame, native mode, memory returns data = addr[15:0] -> exactly 307200 reads, addresses 0..307199, first pixel R/G/B appears on the 145th h-count of line 35 (2-cycle latency), HS low for 96 clocks, VS low for 2 lines.
REQ-023 2x mode -> 76800 reads per frame; lines 2k and 2k+1 read identical addresses; each pixel is shown for 2 columns.
REQ-024 i_rd_data = 16'hF800 -> RGB = FF/00/00; 16'h07E0 -> 00/FF/00; 16'h0010 -> 00/00/84; all 0 during blanking.
REQ-025 i_en dropped mid-frame 2 -> frame 2 completes, o_frame_done pulses once, o_busy falls 2 cycles after the last count; i_scale2x toggled mid-frame -> takes effect only at the next frame.
REQ-026 Build with VGA_TEST_PATTERN_EN defined and i_pattern=1 -> no reads; columns 0..79 are FFFFFF and columns 560..639 are 000000.
